// File: rtl/mem_datos_ctrl.sv
// Load/store controller sitting between the CPU datapath and a word-indexed data memory.
// Takes one byte/half/word request at a time through a valid/ready handshake, checks
// alignment and range, does read-modify-write for sub-word stores and returns extended
// load data with a one-cycle response pulse.
//
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready  request handshake; ready only while idle and out of reset
//   req_we, req_size     1 = store / 0 = load; 00 byte, 01 half, 10 word, 11 illegal
//   req_signed           loads: sign-extend (1) or zero-extend (0)
//   req_addr, req_wdata  byte address, right-aligned store data
//   resp_valid           one-cycle completion pulse
//   resp_rdata, resp_err extended load data (0 for stores/errors), error flag
//   Address, writeData   registered memory word index and write data
//   EnW, EnR             registered memory write / read enables
//   dataOutput           memory read data, combinational from Address
module mem_datos_ctrl #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] Address,
  output logic [31:0]       writeData,
  output logic              EnW,
  output logic              EnR,
  input  logic [31:0]       dataOutput
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e              state_q, state_d;
  logic [1:0]          addr_lo_q, addr_lo_d;
  logic [1:0]          size_q, size_d;
  logic                we_q, we_d;
  logic                signed_q, signed_d;
  // Only the low half is needed later; word stores take req_wdata straight at accept.
  logic [15:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [31:0]         write_data_q, write_data_d;
  logic                en_w_q, en_w_d;
  logic                en_r_q, en_r_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;

  logic [ADDR_W-1:0]   word_idx;
  logic                req_bad;
  logic                accept;
  logic [7:0]          byte_lane;
  logic [15:0]         half_lane;
  logic [31:0]         load_ext;
  logic [31:0]         merged;

  assign req_ready = (state_q == StIdle) && !reset;
  assign accept    = req_valid && req_ready;

  assign word_idx = {2'b00, req_addr[ADDR_W-1:2]};
  assign req_bad  = (req_size == 2'b11)
                 || ((req_size == 2'b01) && req_addr[0])
                 || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                 || (word_idx >= ADDR_W'(DEPTH));

  // Little-endian lane selection on the word currently presented by the memory.
  assign byte_lane = dataOutput[{addr_lo_q, 3'b000} +: 8];
  assign half_lane = addr_lo_q[1] ? dataOutput[31:16] : dataOutput[15:0];

  always_comb begin
    load_ext = dataOutput;
    case (size_q)
      2'b00:   load_ext = signed_q ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
      2'b01:   load_ext = signed_q ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
      default: load_ext = dataOutput;
    endcase
  end

  always_comb begin
    merged = dataOutput;
    if (size_q == 2'b00) begin
      merged[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
    end else if (size_q == 2'b01) begin
      merged[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_lo_d    = addr_lo_q;
    size_d       = size_q;
    we_d         = we_q;
    signed_d     = signed_q;
    wdata_d      = wdata_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    en_w_d       = en_w_q;
    en_r_d       = en_r_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_lo_d = req_addr[1:0];
          size_d    = req_size;
          we_d      = req_we;
          signed_d  = req_signed;
          wdata_d   = req_wdata[15:0];
          if (req_bad) begin
            // No memory access at all; Address is left where it was.
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
            state_d      = StResp;
          end else begin
            address_d = word_idx;
            if (req_we && (req_size == 2'b10)) begin
              write_data_d = req_wdata;
              en_w_d       = 1'b1;
              state_d      = StWr;
            end else begin
              en_r_d  = 1'b1;
              state_d = StRd;
            end
          end
        end
      end
      StRd: begin
        en_r_d = 1'b0;
        if (we_q) begin
          write_data_d = merged;
          en_w_d       = 1'b1;
          state_d      = StWr;
        end else begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = load_ext;
          state_d      = StResp;
        end
      end
      StWr: begin
        en_w_d       = 1'b0;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        state_d      = StResp;
      end
      StResp: begin
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_lo_q    <= 2'b00;
      size_q       <= 2'b00;
      we_q         <= 1'b0;
      signed_q     <= 1'b0;
      wdata_q      <= 16'h0;
      address_q    <= '0;
      write_data_q <= 32'h0;
      en_w_q       <= 1'b0;
      en_r_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      addr_lo_q    <= addr_lo_d;
      size_q       <= size_d;
      we_q         <= we_d;
      signed_q     <= signed_d;
      wdata_q      <= wdata_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      en_w_q       <= en_w_d;
      en_r_q       <= en_r_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign Address    = address_q;
  assign writeData  = write_data_q;
  assign EnW        = en_w_q;
  assign EnR        = en_r_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_datos_ctrl.sv
// Scoreboard bench for mem_datos_ctrl: stimulus pushes expected responses, reads and
// writes into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_datos_ctrl;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'h0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       writeData;
  logic              EnW;
  logic              EnR;
  logic [31:0]       dataOutput;

  mem_datos_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_signed(req_signed),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .Address   (Address),
    .writeData (writeData),
    .EnW       (EnW),
    .EnR       (EnR),
    .dataOutput(dataOutput)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: written only through the DUT.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) if (EnW && (Address < 32'(DEPTH))) mem[Address[5:0]] <= writeData;
  assign dataOutput = (Address < 32'(DEPTH)) ? mem[Address[5:0]] : 32'h0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
    int          resp_at;
    int          rd_at;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] data;
    int          at;
  } wr_t;

  exp_t sb[$];
  wr_t  wq[$];
  int   checks = 0;
  int   failures = 0;
  bit   started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (started && !reset) begin
      chk("req_ready", 32'(req_ready), 32'(sb.size() == 0));
      chk("enr_enw_exclusive", 32'(EnR & EnW), 32'h0);
      if (EnR) begin
        if (sb.size() == 0) chk("unexpected_enr", 32'h1, 32'h0);
        else begin
          chk({sb[0].name, " rd_cycle"}, 32'(cyc), 32'(sb[0].rd_at));
          chk({sb[0].name, " rd_addr"}, Address, sb[0].addr);
        end
      end
      if (EnW) begin
        if (wq.size() == 0) chk("unexpected_enw", 32'h1, 32'h0);
        else begin
          wr_t w;
          w = wq.pop_front();
          chk({w.name, " wr_cycle"}, 32'(cyc), 32'(w.at));
          chk({w.name, " wr_addr"}, Address, w.addr);
          chk({w.name, " wr_data"}, writeData, w.data);
        end
      end
      if (resp_valid) begin
        if (sb.size() == 0) chk("unexpected_resp", 32'h1, 32'h0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, " resp_cycle"}, 32'(cyc), 32'(e.resp_at));
          chk({e.name, " rdata"}, resp_rdata, e.rdata);
          chk({e.name, " err"}, 32'(resp_err), 32'(e.err));
        end
      end
    end
  end

  // Called at posedge+1. Returns at posedge+1 of the cycle following the accept edge.
  task automatic issue(input string name, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input logic [31:0] exp_wdata, input bit hold);
    exp_t e;
    wr_t  w;
    int   n;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      chk({name, " accept_timeout"}, 32'h0, 32'h1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.name  = name;
    e.addr  = addr >> 2;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    w.name  = name;
    w.addr  = addr >> 2;
    w.data  = exp_wdata;
    if (exp_err) begin
      e.rd_at = -1;
      e.resp_at = cyc;
    end else if (!we) begin
      e.rd_at = cyc;
      e.resp_at = cyc + 1;
    end else if (size == 2'b10) begin
      e.rd_at = -1;
      w.at = cyc;
      e.resp_at = cyc + 1;
      wq.push_back(w);
    end else begin
      e.rd_at = cyc;
      w.at = cyc + 1;
      e.resp_at = cyc + 2;
      wq.push_back(w);
    end
    sb.push_back(e);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sb.size() != 0 || wq.size() != 0) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0 || wq.size() != 0) begin
      chk("drain_timeout", 32'(sb.size() + wq.size()), 32'h0);
      sb.delete();
      wq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst Address", Address, 32'h0);
    chk("rst writeData", writeData, 32'h0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst enables", {28'h0, EnW, EnR, resp_valid, resp_err}, 32'h0);
    chk("rst req_ready", 32'(req_ready), 32'h0);
    reset = 1'b0;
    started = 1'b1;
    @(posedge clk);
    #1;

    // Word store then load
    issue("st_w_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
    wait_done();
    issue("ld_w_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    wait_done();

    // Byte read-modify-write
    issue("st_b_12", 1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, 32'h0, 1'b0, 32'hDEAABEEF, 1'b0);
    wait_done();
    issue("ld_w_rmw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAABEEF, 1'b0, 32'h0, 1'b0);
    wait_done();

    // Errors: no memory access, memory unchanged
    issue("err_half_11", 1'b1, 2'b01, 1'b0, 32'h11, 32'h1234, 32'h0, 1'b1, 32'h0, 1'b0);
    wait_done();
    issue("err_word_102", 1'b1, 2'b10, 1'b0, 32'h102, 32'h5555, 32'h0, 1'b1, 32'h0, 1'b0);
    wait_done();
    issue("err_word_100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0);
    wait_done();
    issue("err_size_11", 1'b1, 2'b11, 1'b0, 32'h10, 32'h77, 32'h0, 1'b1, 32'h0, 1'b0);
    wait_done();
    issue("ld_after_err", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAABEEF, 1'b0, 32'h0, 1'b0);
    wait_done();

    // Extension
    issue("st_w_ext", 1'b1, 2'b10, 1'b0, 32'h10, 32'h800080F0, 32'h0, 1'b0, 32'h800080F0, 1'b0);
    wait_done();
    issue("ld_b_s", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'hFFFFFFF0, 1'b0, 32'h0, 1'b0);
    wait_done();
    issue("ld_b_u", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h000000F0, 1'b0, 32'h0, 1'b0);
    wait_done();
    issue("ld_h_s_12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF8000, 1'b0, 32'h0, 1'b0);
    wait_done();
    issue("ld_h_u_10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h000080F0, 1'b0, 32'h0, 1'b0);
    wait_done();

    // Handshake: req_valid held high, alternating stores and loads
    issue("hs_st_w", 1'b1, 2'b10, 1'b0, 32'h14, 32'h01234567, 32'h0, 1'b0, 32'h01234567, 1'b1);
    issue("hs_ld_w", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h01234567, 1'b0, 32'h0, 1'b1);
    issue("hs_st_h", 1'b1, 2'b01, 1'b0, 32'h16, 32'h0000BEEF, 32'h0, 1'b0, 32'hBEEF4567, 1'b1);
    issue("hs_ld_h", 1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 32'h0000BEEF, 1'b0, 32'h0, 1'b1);
    issue("hs_st_b", 1'b1, 2'b00, 1'b0, 32'h15, 32'h00000099, 32'h0, 1'b0, 32'hBEEF9967, 1'b1);
    issue("hs_ld_b", 1'b0, 2'b00, 1'b1, 32'h15, 32'h0, 32'hFFFFFF99, 1'b0, 32'h0, 1'b1);
    issue("hs_ld_w2", 1'b0, 2'b10, 1'b1, 32'h14, 32'h0, 32'hBEEF9967, 1'b0, 32'h0, 1'b0);
    wait_done();

    // Reset abort during the read phase of a byte store
    issue("st_w_20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0, 32'h11223344, 1'b0);
    wait_done();
    issue("st_b_abort", 1'b1, 2'b00, 1'b0, 32'h20, 32'h55, 32'h0, 1'b0, 32'h11223355, 1'b0);
    chk("abort EnR before reset", 32'(EnR), 32'h1);
    reset = 1'b1;
    #1;
    chk("abort EnR drop", 32'(EnR), 32'h0);
    sb.delete();
    wq.delete();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("ready after reset", 32'(req_ready), 32'h1);
    issue("ld_after_abort", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11223344, 1'b0, 32'h0, 1'b0);
    wait_done();
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
